// File: rtl/memory_bus_arbiter_if.sv
// memory_bus_arbiter_if: requester (I/D cache) and external-memory handshake bundle for memory_bus_arbiter
// Signals: i_*/d_* request, address, write data and response per cache port; memory_* to/from the memory.
// Modports: slave = arbiter side, master = environment side (caches + memory).
interface memory_bus_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  i_read_request;
  logic                  i_write_request;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic [DATA_WIDTH-1:0] i_write_data;
  logic [DATA_WIDTH-1:0] i_read_data;
  logic                  i_response;
  logic                  d_read_request;
  logic                  d_write_request;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_write_data;
  logic [DATA_WIDTH-1:0] d_read_data;
  logic                  d_response;
  logic                  memory_read_request;
  logic                  memory_write_request;
  logic [ADDR_WIDTH-1:0] memory_addr;
  logic [DATA_WIDTH-1:0] memory_write_data;
  logic [DATA_WIDTH-1:0] memory_read_data;
  logic                  memory_response;
  logic                  bus_error;
  modport slave (
    input  i_read_request, i_write_request, i_addr, i_write_data,
    input  d_read_request, d_write_request, d_addr, d_write_data,
    input  memory_read_data, memory_response,
    output i_read_data, i_response, d_read_data, d_response,
    output memory_read_request, memory_write_request, memory_addr, memory_write_data, bus_error
  );
  modport master (
    output i_read_request, i_write_request, i_addr, i_write_data,
    output d_read_request, d_write_request, d_addr, d_write_data,
    output memory_read_data, memory_response,
    input  i_read_data, i_response, d_read_data, d_response,
    input  memory_read_request, memory_write_request, memory_addr, memory_write_data, bus_error
  );
endinterface

// File: rtl/memory_bus_arbiter.sv
// memory_bus_arbiter: round-robin sharing of one memory port between I-cache and D-cache, one transaction in flight
// Ports: clk (rising edge), reset (async, active-low), bus (memory_bus_arbiter_if.slave: cache ports + memory port).
// Optional: define ARBITER_TIMEOUT_EN to abort a grant after TIMEOUT_CYCLES cycles with a bus_error pulse.
module memory_bus_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input logic                 clk,
  input logic                 reset,
  memory_bus_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_t;
  state_t                r_state, w_next;
  logic                  r_last_d, r_rd, r_wr;
  logic [ADDR_WIDTH-1:0] r_addr, w_sel_addr;
  logic [DATA_WIDTH-1:0] r_wdata, w_sel_wdata;
  logic                  w_i_pend, w_d_pend, w_pick_d, w_grant, w_done, w_timeout, w_sel_rd, w_sel_wr;
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end
`ifdef ARBITER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] r_cnt;
  // Zero on every IDLE cycle so each grant starts counting from 0; a grant always leaves before LAST+1.
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_cnt <= '0;
    else r_cnt <= (r_state == IDLE || bus.memory_response) ? '0 : r_cnt + 1'b1;
  assign w_timeout = r_state != IDLE && r_cnt == LAST;
`else
  assign w_timeout = 1'b0;
`endif
  always_comb begin
    w_i_pend    = bus.i_read_request | bus.i_write_request;
    w_d_pend    = bus.d_read_request | bus.d_write_request;
    // On a tie the port that did not own the last transaction wins.
    w_pick_d    = w_d_pend & (~w_i_pend | ~r_last_d);
    w_grant     = r_state == IDLE && (w_i_pend || w_d_pend);
    w_done      = r_state != IDLE && (bus.memory_response || w_timeout);
    w_sel_wr    = w_pick_d ? bus.d_write_request : bus.i_write_request;
    w_sel_rd    = ~w_sel_wr & (w_pick_d ? bus.d_read_request : bus.i_read_request);
    w_sel_addr  = w_pick_d ? bus.d_addr : bus.i_addr;
    w_sel_wdata = w_pick_d ? bus.d_write_data : bus.i_write_data;
    w_next      = w_grant ? (w_pick_d ? GRANT_D : GRANT_I) : w_done ? IDLE : r_state;
  end
  // Completion returns to IDLE rather than re-arbitrating, so the requester's still-held request is not re-granted stale.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state  <= IDLE;
      r_last_d <= 1'b0;
      r_rd     <= 1'b0;
      r_wr     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
    end else begin
      r_state <= w_next;
      if (w_grant) begin
        r_rd    <= w_sel_rd;
        r_wr    <= w_sel_wr;
        r_addr  <= w_sel_addr;
        r_wdata <= w_sel_wdata;
      end else if (w_done) begin
        r_rd     <= 1'b0;
        r_wr     <= 1'b0;
        r_last_d <= r_state == GRANT_D;
      end
    end
  assign bus.memory_read_request  = r_rd;
  assign bus.memory_write_request = r_wr;
  assign bus.memory_addr          = r_addr;
  assign bus.memory_write_data    = r_wdata;
  assign bus.i_response           = w_done && r_state == GRANT_I;
  assign bus.d_response           = w_done && r_state == GRANT_D;
  assign bus.i_read_data          = bus.memory_read_data;
  assign bus.d_read_data          = bus.memory_read_data;
  // A response arriving on the timeout cycle wins, so no error is flagged then.
  assign bus.bus_error            = w_timeout & ~bus.memory_response;
endmodule
